// File: rtl/seq_mult_4x4.sv
// Sequential unsigned shift-and-add multiplier built around a 4-bit ripple-carry adder.
// Start/busy/done handshake; one add-and-shift step per CALC cycle, product after 4 steps.
module seq_mult_4x4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               c_q, c_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_sum;
  logic [WIDTH-1:0]   add_co;
  logic               ripple;

  logic               step_c;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   acc_sh;
  logic [WIDTH-1:0]   q_sh;

  // Ripple-carry adder: acc + M with carry-in 0; add_co[WIDTH-1] is the carry-out.
  always_comb begin
    ripple  = 1'b0;
    add_sum = '0;
    add_co  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = acc_q[i] ^ m_q[i] ^ ripple;
      add_co[i]  = (acc_q[i] & m_q[i]) | (ripple & (acc_q[i] ^ m_q[i]));
      ripple     = (acc_q[i] & m_q[i]) | (ripple & (acc_q[i] ^ m_q[i]));
    end
  end

  // c_q is always zero between steps, so the no-add path is simply {C,A}.
  always_comb begin
    if (q_q[0]) begin
      step_c   = add_co[WIDTH-1];
      step_acc = add_sum;
    end else begin
      step_c   = c_q;
      step_acc = acc_q;
    end
    acc_sh = {step_c, step_acc[WIDTH-1:1]};
    q_sh   = {step_acc[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        c_d   = 1'b0;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {acc_sh, q_sh};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= 2'd0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: doc/seq_mult_4x4.md
Name: seq_mult_4x4

Overview:
Sequential 4x4 unsigned shift-and-add multiplier, the stage directly downstream of the team's 4-bit ripple-carry adder. Each iteration it feeds the adder its accumulator and multiplicand, and consumes the adder's 4-bit sum and carry-out (bit 3 of the adder's carry vector). It takes operands with a start/busy/done handshake and returns an 8-bit product after a fixed latency.

Parameters:
WIDTH, 4, operand width; only 4 is supported, to match the 4-bit adder stage.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to start a multiply; sampled only in IDLE or DONE
a  input  4  multiplicand; captured on the accepting edge
b  input  4  multiplier; captured on the accepting edge
busy  output  1  high while in CALC
done  output  1  one-cycle pulse when product is updated
product  output  8  result register; holds until the next completion

Behaviour:
- Reset is synchronous and active-high on clk. When rst=1 at an edge:
  - state <= IDLE; busy=0, done=0, product=8'h00.
  - Internal A, Q, M, C and count are all cleared.
  - rst overrides all other inputs, including mid-CALC; the in-flight operation is discarded and no done pulse is produced.
- Internal registers: M[3:0] multiplicand, Q[3:0] multiplier/low product, A[3:0] accumulator, C carry, cnt[1:0].
- States:
  - IDLE: start=1 is accepted. M<=a, Q<=b, A<=0, C<=0, cnt<=0, go to CALC. Otherwise stay.
  - CALC: busy=1. Each edge performs one combined add-and-shift step:
    - If Q[0]=1, {C,A} = adder sum of A+M with carry-in 0; C is the adder's carry-out. Else {C,A} = {0,A}.
    - Then {C,A,Q} is shifted right by 1 with 0 into the MSB; C is 0 after the shift.
    - cnt increments. On the edge where cnt==3 (4th step), product <= {A,Q} after the shift, and the state goes to DONE.
  - DONE: done=1, busy=0, held for exactly one cycle.
    - start=1 is accepted exactly as in IDLE (back-to-back operation) and the state goes to CALC.
    - Otherwise the state goes to IDLE.
- Latency: if start is accepted at edge E0, CALC covers E1..E4. product is updated and done is high in the cycle after E4, i.e. 4 cycles after acceptance. Throughput is one result per 5 cycles with back-to-back starts.
- start is ignored while busy=1. Changes to a or b after acceptance have no effect.
- product changes only at the 4th CALC edge or on reset. It is stable at all other times, including throughout the next operation until that operation completes.
- Arithmetic:
  - Unsigned only; the result is exact and cannot overflow 8 bits (max 15*15=225).
  - The 4-bit adder's carry-out must be retained in C and shifted into A[3]. Dropping it corrupts results, e.g. 15*15.
- Outputs are registered. busy and done are decoded from the state register only, with no combinational path from start.

Test Plan:
1. rst=1 for 2 cycles, then release → product=0x00, busy=0, done=0. start=0 for 10 cycles → no change.
2. a=13, b=11, start pulse at E0 → busy=1 for cycles after E0..E3; done=1 for one cycle after E4; product=0x8F (143).
3. a=15, b=15 → product=0xE1 (225), which checks carry retention. a=0, b=9 → 0x00. a=9, b=0 → 0x00. a=1, b=1 → 0x01.
4. a=6, b=7 started, then start=1 with a=3, b=3 held during CALC → second request ignored. product=0x2A (42), single done pulse.
5. Back-to-back: start held high with a=5, b=5, then a=12, b=10 presented in the DONE cycle → done pulses 5 cycles apart; product=0x19 (25) then 0x78 (120).
6. Reset mid-op: start a=15, b=14, assert rst at E2 → busy=0, done stays 0, product=0x00. Then full exhaustive sweep of all 256 a/b pairs matches a*b.
